v3_filter_mc: RTL and testbench

V3_FILTER_MC -- requirements
Module: v3_filter_mc

---
 rtl/v3_filter_mc_pkg.sv | 18 +
 rtl/v3_channel.sv | 80 ++++++++
 rtl/v3_filter_mc.sv | 56 +++++
 tb/tb_v3_filter_mc.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/v3_filter_mc_pkg.sv
// v3_filter_mc_pkg: default filter constants and the output saturation helper
package v3_filter_mc_pkg;
    localparam int SIZE_ADC_DATA = 12;
    localparam int K_DEF = 8;
    localparam int L_DEF = 8;
    localparam int M1_DEF = 16;
    localparam int M2_DEF = 1;
    localparam int SHIFT_DEF = 8;
    localparam int PIPE_D = 5;
    // Clamp x into the signed range of a w-bit value.
    function automatic logic signed [63:0] sat_val(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return (x > hi) ? hi : ((x < lo) ? lo : x);
    endfunction
endpackage

// File: rtl/v3_channel.sv
// v3_channel: one channel of the trapezoid filter with delayed, saturated output
module v3_channel
    import v3_filter_mc_pkg::*;
#(
    parameter int DATA_W = SIZE_ADC_DATA,
    parameter int OUT_W = DATA_W,
    parameter int ACC_W = 4 * DATA_W,
    parameter int K = K_DEF,
    parameter int L = L_DEF,
    parameter int M1 = M1_DEF,
    parameter int M2 = M2_DEF,
    parameter int SHIFT = SHIFT_DEF
) (
    input  logic                    clk,
    input  logic                    i_reset,
    input  logic                    i_clear,
    input  logic                    i_valid,
    input  logic [DATA_W-1:0]       i_data,
    output logic signed [OUT_W-1:0] o_data,
    output logic                    o_ovf
);
    localparam logic signed [ACC_W-1:0] C_K = ACC_W'(K);
    localparam logic signed [ACC_W-1:0] C_M1 = ACC_W'(M1);
    localparam logic signed [ACC_W-1:0] C_M2 = ACC_W'(M2);
    logic signed [ACC_W-1:0] r_v [K];
    logic signed [ACC_W-1:0] r_d1 [L];
    // r_sh[0] doubles as s(n-1); r_sh[PIPE_D-1] is the sample being emitted
    logic signed [ACC_W-1:0] r_sh [PIPE_D];
    logic signed [ACC_W-1:0] r_p;
    logic signed [ACC_W-1:0] r_q;
    logic signed [OUT_W-1:0] r_out;
    logic                    r_ovf;
    logic signed [ACC_W-1:0] w_v;
    logic signed [ACC_W-1:0] w_d1;
    logic signed [ACC_W-1:0] w_p;
    logic signed [ACC_W-1:0] w_q;
    logic signed [ACC_W-1:0] w_s;
    logic signed [ACC_W-1:0] w_shift;
    logic signed [63:0]      w_ext;
    logic signed [63:0]      w_sat;
    logic                    w_clip;

    always_comb begin
        w_v = ACC_W'(i_data);
        w_d1 = w_v - r_v[0];
        w_p = r_p + (w_v - r_v[K-1]) - C_K * r_d1[L-1];
        w_q = r_q + C_M2 * w_p;
        w_s = r_sh[0] + w_q + C_M1 * w_p;
        w_shift = r_sh[PIPE_D-1] >>> SHIFT;
        w_ext = 64'(w_shift);
        w_sat = sat_val(w_ext, OUT_W);
        w_clip = w_sat != w_ext;
    end

    always_ff @(posedge clk) begin
        if (i_reset || i_clear) begin
            for (int i = 0; i < K; i++) r_v[i] <= '0;
            for (int i = 0; i < L; i++) r_d1[i] <= '0;
            for (int i = 0; i < PIPE_D; i++) r_sh[i] <= '0;
            r_p <= '0;
            r_q <= '0;
            r_out <= '0;
            r_ovf <= 1'b0;
        end else if (i_valid) begin
            r_v[0] <= w_v;
            for (int i = 1; i < K; i++) r_v[i] <= r_v[i-1];
            r_d1[0] <= w_d1;
            for (int i = 1; i < L; i++) r_d1[i] <= r_d1[i-1];
            r_sh[0] <= w_s;
            for (int i = 1; i < PIPE_D; i++) r_sh[i] <= r_sh[i-1];
            r_p <= w_p;
            r_q <= w_q;
            r_out <= w_sat[OUT_W-1:0];
            r_ovf <= r_ovf | w_clip;
        end
    end

    assign o_data = r_out;
    assign o_ovf = r_ovf;
endmodule

// File: rtl/v3_filter_mc.sv
// v3_filter_mc: N_CH parallel trapezoid filters sharing one valid strobe
module v3_filter_mc
    import v3_filter_mc_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int DATA_W = SIZE_ADC_DATA,
    parameter int OUT_W = DATA_W,
    parameter int ACC_W = 4 * DATA_W,
    parameter int K = K_DEF,
    parameter int L = L_DEF,
    parameter int M1 = M1_DEF,
    parameter int M2 = M2_DEF,
    parameter int SHIFT = SHIFT_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   in_valid,
    input  logic [N_CH*DATA_W-1:0] in_data,
    output logic                   out_valid,
    output logic [N_CH*OUT_W-1:0]  out_data,
    output logic [N_CH-1:0]        ovf
);
    logic r_out_valid;

    if (K < 1 || L < 1 || SHIFT >= ACC_W || OUT_W > ACC_W || ACC_W > 64) begin : g_bad_param
        $fatal(1, "v3_filter_mc: illegal parameter combination");
    end

    always_ff @(posedge clk) begin
        r_out_valid <= !(reset || clear) && in_valid;
    end

    assign out_valid = r_out_valid;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        v3_channel #(
            .DATA_W(DATA_W),
            .OUT_W(OUT_W),
            .ACC_W(ACC_W),
            .K(K),
            .L(L),
            .M1(M1),
            .M2(M2),
            .SHIFT(SHIFT)
        ) u_ch (
            .clk(clk),
            .i_reset(reset),
            .i_clear(clear),
            .i_valid(in_valid),
            .i_data(in_data[c*DATA_W +: DATA_W]),
            .o_data(out_data[c*OUT_W +: OUT_W]),
            .o_ovf(ovf[c])
        );
    end
endmodule

// File: tb/tb_v3_filter_mc.sv
// tb_v3_filter_mc: random and directed stimulus against a sample-indexed reference model
module tb_v3_filter_mc;
    localparam int K_T = 8;
    localparam int L_T = 8;
    localparam int PD = 5;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        in_valid;
    logic [47:0] a_in;
    logic [47:0] a_out;
    logic [3:0]  a_ovf;
    logic        a_vld;
    logic [15:0] b_in;
    logic [15:0] b_out;
    logic [1:0]  b_ovf;
    logic        b_vld;

    int n_checks = 0;
    int n_err = 0;

    // model channels 0..3 belong to instance A, 4..5 to instance B
    int p_ow [6] = '{12, 12, 12, 12, 8, 8};
    int p_aw [6] = '{48, 48, 48, 48, 32, 32};
    int p_m1 [6] = '{16, 16, 16, 16, 1, 1};
    int p_m2 [6] = '{1, 1, 1, 1, 0, 0};
    int p_sh [6] = '{8, 8, 8, 8, 0, 0};
    longint vq [6][$];
    longint sq [6][$];
    longint pm [6];
    longint qm [6];
    longint sm [6];
    longint exp_o [6];
    bit     exp_ov [6];
    bit     exp_vld;

    v3_filter_mc dut_a (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
        .in_data(a_in), .out_valid(a_vld), .out_data(a_out), .ovf(a_ovf)
    );

    v3_filter_mc #(
        .N_CH(2), .DATA_W(8), .OUT_W(8), .ACC_W(32), .M1(1), .M2(0), .SHIFT(0)
    ) dut_b (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
        .in_data(b_in), .out_valid(b_vld), .out_data(b_out), .ovf(b_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint vget(int idx, int i);
        return (i < 0) ? 0 : vq[idx][i];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 6; i++) begin
            vq[i].delete();
            sq[i].delete();
            pm[i] = 0;
            qm[i] = 0;
            sm[i] = 0;
            exp_o[i] = 0;
            exp_ov[i] = 0;
        end
    endtask

    task automatic model_step(int idx, longint v);
        int n;
        longint p;
        longint s_old;
        longint x;
        longint hi;
        n = vq[idx].size();
        vq[idx].push_back(v);
        p = pm[idx] + (v - vget(idx, n - K_T)) - K_T * (vget(idx, n - L_T) - vget(idx, n - L_T - 1));
        qm[idx] = qm[idx] + p_m2[idx] * p;
        sm[idx] = sm[idx] + qm[idx] + p_m1[idx] * p;
        pm[idx] = p;
        sq[idx].push_back(sm[idx]);
        s_old = (n >= PD) ? sq[idx][n - PD] : 0;
        x = (s_old <<< (64 - p_aw[idx])) >>> (64 - p_aw[idx]);
        x = x >>> p_sh[idx];
        hi = (64'sd1 <<< (p_ow[idx] - 1)) - 1;
        if (x > hi) begin
            exp_o[idx] = hi;
            exp_ov[idx] = 1'b1;
        end else if (x < -hi - 1) begin
            exp_o[idx] = -hi - 1;
            exp_ov[idx] = 1'b1;
        end else begin
            exp_o[idx] = x;
        end
    endtask

    task automatic tick(input bit r, input bit cl, input bit v, input logic [47:0] da, input logic [15:0] db);
        reset = r;
        clear = cl;
        in_valid = v;
        a_in = da;
        b_in = db;
        @(posedge clk);
        exp_vld = v && !r && !cl;
        if (r || cl) model_clear();
        else if (v) begin
            for (int c = 0; c < 4; c++) model_step(c, longint'(da[c*12 +: 12]));
            for (int c = 0; c < 2; c++) model_step(4 + c, longint'(db[c*8 +: 8]));
        end
        @(negedge clk);
        chk("a_vld", a_vld, exp_vld);
        chk("b_vld", b_vld, exp_vld);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("a_out%0d", c), $signed(a_out[c*12 +: 12]), exp_o[c]);
            chk($sformatf("a_ovf%0d", c), a_ovf[c], exp_ov[c]);
        end
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("b_out%0d", c), $signed(b_out[c*8 +: 8]), exp_o[4 + c]);
            chk($sformatf("b_ovf%0d", c), b_ovf[c], exp_ov[4 + c]);
        end
    endtask

    initial begin
        logic [47:0] da;
        logic [15:0] db;
        int ramp;
        model_clear();
        exp_vld = 0;
        tick(1, 0, 0, '0, '0);
        tick(1, 0, 1, '1, '1);
        // step of 10 on channel 0 only
        for (int i = 0; i < 40; i++) tick(0, 0, 1, 48'd10, 16'd10);
        // reset mid-step, then restart the step
        tick(1, 0, 1, 48'd10, 16'd10);
        for (int i = 0; i < 20; i++) tick(0, 0, 1, 48'd10, 16'd10);
        // constant level on every channel
        tick(1, 0, 0, '0, '0);
        for (int i = 0; i < 64; i++) tick(0, 0, 1, {4{12'd1000}}, {2{8'd200}});
        // clear together with a valid sample, which must be discarded
        tick(0, 1, 1, {4{12'd1000}}, {2{8'd200}});
        for (int i = 0; i < 10; i++) tick(0, 0, 1, {4{12'd7}}, {2{8'd3}});
        // ramp with in_valid only every third cycle
        tick(0, 1, 0, '0, '0);
        ramp = 0;
        for (int i = 0; i < 60; i++) begin
            if (i % 3 == 0) ramp++;
            tick(0, 0, (i % 3 == 0), {4{12'(ramp)}}, {2{8'(ramp)}});
        end
        // saturation: full-scale step then back to zero, ovf must stay set
        tick(1, 0, 0, '0, '0);
        for (int i = 0; i < 20; i++) tick(0, 0, 1, 48'd0, {8'd0, 8'd255});
        for (int i = 0; i < 20; i++) tick(0, 0, 1, 48'd0, 16'd0);
        // random traffic with occasional clear and reset
        for (int i = 0; i < 300; i++) begin
            bit big;
            big = ($urandom_range(0, 3) == 0);
            for (int c = 0; c < 4; c++) da[c*12 +: 12] = big ? 12'($urandom_range(0, 4095)) : 12'($urandom_range(0, 40));
            for (int c = 0; c < 2; c++) db[c*8 +: 8] = big ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 20));
            tick(($urandom_range(0, 79) == 0), ($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), da, db);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
